// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Brief    : Iterative restoring RV32M divider (DIV/DIVU/REM/REMU) that writes
//            its result straight into the register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [4:0]            rd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_en,
    output logic [4:0]            wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] c_min_neg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state, w_state_nx;

    logic [DATA_WIDTH-1:0] r_rem, r_quo, r_dvsr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_op_rem, r_neg_q, r_neg_r;

    // Operand decode at acceptance
    logic                  w_signed, w_s1_neg, w_s2_neg, w_div0, w_ovf, w_special;
    logic [DATA_WIDTH-1:0] w_a_mag, w_b_mag, w_spec_res;

    assign w_signed   = ~op[0];
    assign w_s1_neg   = w_signed & rs1_data[DATA_WIDTH-1];
    assign w_s2_neg   = w_signed & rs2_data[DATA_WIDTH-1];
    assign w_a_mag    = w_s1_neg ? (~rs1_data + 1'b1) : rs1_data;
    assign w_b_mag    = w_s2_neg ? (~rs2_data + 1'b1) : rs2_data;
    assign w_div0     = (rs2_data == '0);
    assign w_ovf      = w_signed && (rs1_data == c_min_neg) && (rs2_data == '1);
    assign w_special  = w_div0 | w_ovf;
    assign w_spec_res = w_div0 ? (op[1] ? rs1_data : '1)
                               : (op[1] ? '0 : c_min_neg);

    // One restoring step: the remainder never exceeds the divisor, so only the
    // extra trial bit is needed to detect a borrow.
    logic [DATA_WIDTH:0]   w_rem_sh, w_trial;
    logic                  w_take;
    logic [DATA_WIDTH-1:0] w_rem_nx, w_quo_nx, w_q_fin, w_r_fin, w_calc_res;

    assign w_rem_sh   = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_dvsr};
    assign w_take     = ~w_trial[DATA_WIDTH];
    assign w_rem_nx   = w_take ? w_trial[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0];
    assign w_quo_nx   = {r_quo[DATA_WIDTH-2:0], w_take};
    assign w_q_fin    = r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
    assign w_r_fin    = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;
    assign w_calc_res = r_op_rem ? w_r_fin : w_q_fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nx = w_special ? DONE : CALC;
            CALC:    if (r_cnt == '0) w_state_nx = DONE;
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_cnt    <= '0;
            r_op_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            done  <= 1'b0;
            wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op_rem <= op[1];
                        wr_addr  <= rd_in;
                        r_rem    <= '0;
                        r_quo    <= w_a_mag;
                        r_dvsr   <= w_b_mag;
                        r_neg_q  <= w_s1_neg ^ w_s2_neg;
                        r_neg_r  <= w_s1_neg;
                        busy     <= 1'b1;
                        if (w_special) begin
                            wr_data <= w_spec_res;
                            done    <= 1'b1;
                            wr_en   <= (rd_in != 5'd0);
                        end else begin
                            r_cnt <= CNT_W'(DATA_WIDTH - 1);
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    if (r_cnt == '0) begin
                        wr_data <= w_calc_res;
                        done    <= 1'b1;
                        wr_en   <= (wr_addr != 5'd0);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                DONE:    busy <= 1'b0;
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module   : tb_div_unit
// Brief    : Directed self-checking bench for div_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_in    (rd_in),
        .busy     (busy),
        .done     (done),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one operation from just after a rising edge and follows it to the
    // first IDLE cycle, so consecutive calls run back to back.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input bit special, input bit disturb);
        int n = 0;
        int busy_hi = 0;
        op = o; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, ":busy_e0"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_hi++;
            @(posedge clk); #1;
            n++;
            if (disturb && n == 5) begin
                start = 1'b1; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'd1;
                op = ~o; rd_in = 5'd7;
            end
            if (disturb && n == 6) start = 1'b0;
        end
        if (busy === 1'b1) busy_hi++;
        check({tag, ":done"},    32'(done), 32'd1);
        check({tag, ":latency"}, n, special ? 32'd0 : 32'd32);
        check({tag, ":busy_cycles"}, busy_hi, special ? 32'd1 : 32'd33);
        check({tag, ":wr_en"},   32'(wr_en), 32'(rd != 5'd0));
        check({tag, ":wr_addr"}, 32'(wr_addr), 32'(rd));
        check({tag, ":wr_data"}, wr_data, exp);
        @(posedge clk); #1;
        check({tag, ":busy_end"},  32'(busy), 32'd0);
        check({tag, ":done_end"},  32'(done), 32'd0);
        check({tag, ":wr_en_end"}, 32'(wr_en), 32'd0);
    endtask

    initial begin
        int stray;
        // Reset with start asserted: nothing may come out
        start = 1'b1; op = 2'b01; rs1_data = 32'd9; rs2_data = 32'd3; rd_in = 5'd4;
        repeat (3) @(posedge clk);
        #1;
        check("rst:busy",    32'(busy), 32'd0);
        check("rst:done",    32'(done), 32'd0);
        check("rst:wr_en",   32'(wr_en), 32'd0);
        check("rst:wr_addr", 32'(wr_addr), 32'd0);
        check("rst:wr_data", wr_data, 32'd0);
        start = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst:busy", 32'(busy), 32'd0);
        check("post_rst:done", 32'(done), 32'd0);

        do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0, 1'b0);
        do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd5, 32'd2,  1'b0, 1'b0);
        do_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 1'b0, 1'b0);
        do_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 5'd31, 32'd1, 1'b0, 1'b0);
        do_op("div_42_0",   2'b00, 32'd42, 32'd0, 5'd6, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op("remu_42_0",  2'b11, 32'd42, 32'd0, 5'd6, 32'd42, 1'b1, 1'b0);
        do_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1'b1, 1'b0);
        do_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 1'b1, 1'b0);
        do_op("divu_big",   2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 1'b0, 1'b0);
        do_op("remu_big",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1'b0, 1'b0);
        do_op("divu_disturb", 2'b01, 32'hFFFF_FFFF, 32'd3, 5'd12, 32'h5555_5555, 1'b0, 1'b1);
        do_op("divu_rd0",   2'b01, 32'd1000, 32'd10, 5'd0, 32'd100, 1'b0, 1'b0);
        do_op("divu_b2b",   2'b01, 32'd12345, 32'd100, 5'd1, 32'd123, 1'b0, 1'b0);

        // Reset in the middle of an iteration run: no write may follow
        op = 2'b01; rs1_data = 32'd1000; rs2_data = 32'd3; rd_in = 5'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (16) begin
            @(posedge clk); #1;
        end
        check("midrst:busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst:busy",    32'(busy), 32'd0);
        check("midrst:wr_en",   32'(wr_en), 32'd0);
        check("midrst:wr_data", wr_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || wr_en === 1'b1 || busy === 1'b1) stray++;
        end
        check("midrst:no_activity", stray, 32'd0);

        do_op("after_midrst", 2'b00, 32'd100, 32'hFFFF_FFF9, 5'd2, 32'hFFFF_FFF2, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_unit.md
# div_unit

Iterative RV32M divider: executes DIV, DIVU, REM and REMU over several cycles. It takes its operands from the register-file read ports (rs1/rs2 data) and drives the register-file write port (wr_en/wr_addr/wr_data) with the result. The core's main datapath stalls while `busy` is high. The block is a restoring shift-subtract divider producing one quotient bit per cycle, with RISC-V special cases resolved in a single cycle.

## Interface
- DATA_WIDTH, 32, operand/result width; also the iteration count
- clk  input  1  rising-edge clock shared with the register file
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1_data  input  DATA_WIDTH  dividend
- rs2_data  input  DATA_WIDTH  divisor
- rd_in  input  5  destination register index
- busy  output  1  high from the cycle after start is accepted until the cycle after done
- done  output  1  one-cycle completion pulse
- wr_en  output  1  register-file write enable
- wr_addr  output  5  register-file write index (latched rd_in)
- wr_data  output  DATA_WIDTH  result (quotient or remainder per op)

## Operation
- States: IDLE, CALC, DONE. All state is reset asynchronously by rst_n low.
- Reset values: state IDLE, counter 0, busy 0, done 0, wr_en 0, wr_addr 0, wr_data 0, internal registers 0.
- IDLE with start=1: latch op, rd_in, rs1_data and rs2_data.
  - Divisor == 0 → DONE. Quotient = all ones; remainder = dividend.
  - Signed op with dividend = 0x8000_0000 and divisor = 0xFFFF_FFFF → DONE. Quotient = 0x8000_0000; remainder = 0.
  - Otherwise → CALC with counter = DATA_WIDTH-1.
- Signed ops: divide the magnitudes unsigned, then apply signs:
  - The quotient is negated if the operand signs differ.
  - The remainder takes the dividend's sign.
  - Unsigned ops use the raw operands.
- CALC, each cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem_shifted − divisor, at DATA_WIDTH+1 bits.
  - If the trial is non-negative, rem = trial and quo LSB = 1.
  - The counter decrements; at 0 → DONE.
- DONE:
  - done = 1.
  - wr_data = quotient (op[1]=0) or remainder (op[1]=1), sign-corrected.
  - wr_addr = latched rd.
  - wr_en = 1 unless the latched rd == 0.
  - Next edge → IDLE.
- start is ignored in CALC and DONE. The latched operands are immune to input changes after acceptance.
- rd = 0: the full computation runs and done pulses, but wr_en stays 0.
- Reset mid-operation: immediate return to IDLE; no write is issued.

## Timing
- Edge E0 accepts start. busy = 1 from E0 to the edge that leaves DONE.
- Normal op: CALC occupies E0..E32 (32 iterations). DONE is the cycle after E32. The register file captures the result at E33. busy falls at E33.
- Special case: DONE is the cycle after E0, the write occurs at E1, and busy falls at E1.
- done and wr_en are high for exactly one cycle and coincide.
- A new start may be presented in the first IDLE cycle (E33/E1). Back-to-back ops therefore cost 34 cycles each, or 2 cycles for a special case.
- wr_data, wr_addr and wr_en are registered outputs with no combinational path from the inputs.

## Test plan
- Reset: with rst_n low, busy/done/wr_en = 0. Assert start; on release, nothing happens until start is re-sampled in IDLE.
- DIVU 100/7, rd = 5: busy for 33 cycles; done with wr_en = 1, wr_addr = 5, wr_data = 14. REMU on the same operands → 2.
- Signed: DIV −7/2 → 0xFFFF_FFFD (−3); REM −7/2 → 0xFFFF_FFFF (−1); REM 7/−2 → 1.
- Divide by zero: DIV 42/0 → 0xFFFF_FFFF; REMU 42/0 → 42; done the cycle after E0.
- Overflow: DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000; REM of the same → 0; single-cycle path.
- Robustness:
  - start pulsed during CALC is ignored.
  - rd = 0 gives done without wr_en.
  - rst_n low at iteration 16 → IDLE, no write.
  - A back-to-back DIVU starting in the first IDLE cycle completes correctly.
